register_file: RTL and testbench

Parametrised MIPS general-purpose register file: an array of `DEPTH` registers of `N` bits with two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero. Two registers have non-zero reset values: `$gp`/28 and `$sp`/29. An optional same-cycle write-to-read bypass removes the need for split-cycle register-file timing in the pipelined datapath. The block sits in the decode stage, between the instruction register and the ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/register_cell.sv | 19 +
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: architectural register indices and
// default reset values for the global and stack pointers.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;

  // Reset contents of register idx, before fitting to the register width.
  function automatic logic [31:0] reset_value(input int idx, input logic [31:0] gp,
                                              input logic [31:0] sp);
    if (idx == REG_GP) return gp;
    if (idx == REG_SP) return sp;
    return 32'h0;
  endfunction

endpackage

// File: rtl/register_cell.sv
// One register-file entry: N-bit flop with enable and a per-instance
// reset value, cleared asynchronously while reset is low.
module register_cell #(
  parameter int           N       = 32,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: two combinational read ports, one
// clocked write port, hardwired zero register and optional write bypass.
module register_file
  import mips_pkg::*;
#(
  parameter int          N       = DATA_W,
  parameter int          DEPTH   = 32,
  parameter int          ADDR_W  = $clog2(DEPTH),
  parameter logic [31:0] SP_INIT = SP_INIT_DEF,
  parameter logic [31:0] GP_INIT = GP_INIT_DEF,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [N-1:0]      WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [N-1:0]      ReadData1,
  output logic [N-1:0]      ReadData2
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0][N-1:0] regs;
  logic                    hit1;
  logic                    hit2;

  // Entry 0 has no storage; it is a constant that the read muxes select.
  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    localparam logic [N-1:0] RV = N'(reset_value(i, GP_INIT, SP_INIT));
    logic wen;
    assign wen = RegWrite && (WriteRegister == ADDR_W'(i));
    register_cell #(
      .N       (N),
      .RST_VAL (RV)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (wen),
      .d     (WriteData),
      .q     (regs[i])
    );
  end

  // Forwarding is suppressed in reset so outputs track the reset contents.
  always_comb begin
    hit1 = BYPASS && reset && RegWrite &&
           (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_ADDR);
    hit2 = BYPASS && reset && RegWrite &&
           (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_ADDR);
    ReadData1 = hit1 ? WriteData : regs[ReadRegister1];
    ReadData2 = hit2 ? WriteData : regs[ReadRegister2];
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: bypassed and non-bypassed 32x32
// instances share stimulus; a 16-bit, 64-entry instance covers the sweep.
module tb_register_file;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wd = '0;
  logic [31:0] a1, a2, b1, b2;

  logic        c_we = 1'b0;
  logic [5:0]  c_wa = '0, c_ra1 = '0, c_ra2 = '0;
  logic [15:0] c_wd = '0;
  logic [15:0] c1, c2;

  logic [31:0] mdl [32];
  logic [15:0] mdl_c [64];
  logic [31:0] exq [$];
  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  register_file #(.BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(a1), .ReadData2(a2));

  register_file #(.BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(b1), .ReadData2(b2));

  register_file #(.N(16), .DEPTH(64), .BYPASS(1'b1)) u_c (
    .clk(clk), .reset(reset), .RegWrite(c_we), .WriteRegister(c_wa), .WriteData(c_wd),
    .ReadRegister1(c_ra1), .ReadRegister2(c_ra2), .ReadData1(c1), .ReadData2(c2));

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 64; i++) mdl_c[i] = '0;
    mdl[28]   = 32'h1000_8000;
    mdl[29]   = 32'h7FFF_EFFC;
    mdl_c[28] = 16'h8000;
    mdl_c[29] = 16'hEFFC;
  endtask

  task automatic model_write();
    if (reset && we && wa != 0) mdl[wa] = wd;
    if (reset && c_we && c_wa != 0) mdl_c[c_wa] = c_wd;
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
    if (byp && reset && we && wa == ra && ra != 0) return wd;
    return mdl[ra];
  endfunction

  // Expected order: u_a port1, u_a port2, u_b port1, u_b port2.
  task automatic push_exp();
    exq.push_back(exp_rd(1'b1, ra1));
    exq.push_back(exp_rd(1'b1, ra2));
    exq.push_back(exp_rd(1'b0, ra1));
    exq.push_back(exp_rd(1'b0, ra2));
  endtask

  task automatic test_reset();
    logic [31:0] obs [4];
    logic [4:0]  addrs [4];
    logic [31:0] e;
    addrs = '{5'd0, 5'd28, 5'd29, 5'd5};
    #1 reset = 1'b0;
    model_reset();
    for (int j = 0; j < 4; j++) begin
      ra1 = addrs[j];
      ra2 = addrs[j];
      push_exp();
      #1;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
        e = exq.pop_front();
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL reset_r%0d port%0d got=%h exp=%h", addrs[j], k, obs[k], e);
        end
      end
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_basic_write();
    logic [31:0] obs [4];
    logic [31:0] e;
    @(negedge clk);
    we = 1'b1; wa = 5'd8; wd = 32'hDEAD_BEEF; ra1 = 5'd8; ra2 = 5'd8;
    @(posedge clk) model_write();
    @(negedge clk) we = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (j == 1) begin ra1 = 5'd28; ra2 = 5'd5; end
      push_exp();
      #1;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
        e = exq.pop_front();
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL basic_write_%0d port%0d got=%h exp=%h", j, k, obs[k], e);
        end
      end
    end
  endtask

  // Shared shape for zero-register and bypass scenarios: pre-edge then post-edge.
  task automatic test_write_pair(input string tag, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] obs [4];
    logic [31:0] e;
    @(negedge clk);
    we = 1'b1; wa = a; wd = d; ra1 = a; ra2 = a;
    for (int j = 0; j < 2; j++) begin
      push_exp();
      #1;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
        e = exq.pop_front();
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL %s_%s port%0d got=%h exp=%h", tag, (j == 0) ? "pre" : "post",
                   k, obs[k], e);
        end
      end
      if (j == 0) begin
        @(posedge clk) model_write();
        @(negedge clk) we = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] obs [4];
    logic [31:0] e;
    test_write_pair("mid_reset_wr29", 5'd29, 32'hAAAA_0000);
    for (int j = 0; j < 4; j++) begin
      case (j)
        0: begin
          #2;
          we = 1'b1; wa = 5'd29; wd = 32'h5555_5555; ra1 = 5'd29; ra2 = 5'd28;
          reset = 1'b0;
          model_reset();
        end
        1: begin
          @(posedge clk) model_write();
          @(negedge clk);
        end
        2: begin
          reset = 1'b1;
          wd = 32'hCAFE_F00D;
        end
        default: begin
          @(posedge clk) model_write();
          @(negedge clk) we = 1'b0;
        end
      endcase
      push_exp();
      #1;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
        e = exq.pop_front();
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL mid_reset_step%0d port%0d got=%h exp=%h", j, k, obs[k], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs [4];
    logic [31:0] e;
    logic [4:0]  prev;
    prev = 5'd9;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we = 1'b1;
      wa = 5'($urandom_range(31, 1));
      wd = $urandom;
      ra1 = wa;
      ra2 = prev;
      push_exp();
      #1;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
        e = exq.pop_front();
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL b2b_w%0d port%0d got=%h exp=%h", i, k, obs[k], e);
        end
      end
      prev = wa;
      @(posedge clk) model_write();
    end
    @(negedge clk) we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      push_exp();
      #1;
      obs = '{a1, a2, b1, b2};
      for (int k = 0; k < 4; k++) begin
        e = exq.pop_front();
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL b2b_readback_r%0d port%0d got=%h exp=%h", i, k, obs[k], e);
        end
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] obs [2];
    logic [31:0] e;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      case (j)
        0: begin c_ra1 = 6'd29; c_ra2 = 6'd28; end
        1: begin c_we = 1'b1; c_wa = 6'd63; c_wd = 16'hBEEF; c_ra1 = 6'd63; c_ra2 = 6'd62; end
        default: begin
          @(posedge clk) model_write();
          @(negedge clk) c_we = 1'b0;
        end
      endcase
      exq.push_back({16'h0, (reset && c_we && c_wa == c_ra1 && c_ra1 != 0) ? c_wd : mdl_c[c_ra1]});
      exq.push_back({16'h0, (reset && c_we && c_wa == c_ra2 && c_ra2 != 0) ? c_wd : mdl_c[c_ra2]});
      #1;
      obs = '{c1, c2};
      for (int k = 0; k < 2; k++) begin
        e = exq.pop_front();
        checks++;
        if ({16'h0, obs[k]} !== e) begin
          failures++;
          $display("FAIL sweep_step%0d port%0d got=%h exp=%h", j, k, obs[k], e[15:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_write_pair("zero_reg", 5'd0, 32'hFFFF_FFFF);
    test_write_pair("bypass_r9", 5'd9, 32'h1234_5678);
    test_mid_reset();
    test_back_to_back();
    test_param_sweep();
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
